wb_skid_stage: RTL and testbench
================================

# wb_skid_stage

Parametrised MEM→WB pipeline stage for the XPU core. It carries NCH independent write-back channels (channel 0 = GPR, channel 1 = CSR by default) through a 2-entry skid buffer with a valid/ready handshake, which replaces the single-register Block-style stall. It also provides an address-lookup bypass port so ID/EX hazard logic can forward data still held in the stage.

## Interface
Parameters:
- NCH, 2, number of write-back channels
- DW, 64, data width per channel
- AW, 12, address width per channel; narrower addresses (GPR, 5 bits) are zero-extended by the producer

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream (MEM) holds a valid entry
- in_ready  out  1  stage can accept an entry this cycle
- in_wen  in  NCH  per-channel write enable
- in_waddr  in  NCH*AW  per-channel destination address, channel c at [c*AW +: AW]
- in_wdata  in  NCH*DW  per-channel write data
- flush  in  1  discard all held entries
- out_valid  out  1  head entry is valid
- out_ready  in  1  write-back consumer accepts the head
- out_wen / out_waddr / out_wdata  out  NCH / NCH*AW / NCH*DW  head entry
- lkp_addr  in  NCH*AW  per-channel lookup address
- lkp_hit  out  NCH  lookup matched a held entry
- lkp_data  out  NCH*DW  forwarded data for a hit

## Operation
- Storage: two slots (s0, s1), each holding valid, wen[NCH], waddr, wdata. Head = oldest valid slot. A 2-bit occupancy count (0..2) and a 1-bit head pointer are kept.
- Push: in_valid & in_ready. The entry is written to the tail slot.
- Pop: out_valid & out_ready. The head pointer advances and the slot's valid bit clears.
- in_ready = (count != 2). It depends only on registered state and never on out_ready.
- out_valid = (count != 0). out_wen = head.wen & {NCH{out_valid}}. out_waddr and out_wdata carry the raw head slot contents.
- Simultaneous push and pop at count 1: count stays 1, the head moves to the new entry, and the head pointer toggles.
- Simultaneous push and pop at count 0: cannot occur because out_valid is 0.
- Flush has priority over push and pop in the same cycle. All valid bits clear, count goes to 0, and the head pointer goes to 0. The incoming entry is dropped.
- Lookup, per channel c: scan valid slots with wen[c]=1 and waddr[c]==lkp_addr[c]. The newest match wins. lkp_hit[c]=1 and lkp_data[c] = that slot's wdata[c]. With no match, lkp_hit=0 and lkp_data=0. The incoming (unregistered) entry is not searched. Lookup is purely combinational.
- Channels are independent. An entry may write any subset of channels, including none; an all-zero wen entry is a bubble that still occupies a slot.

## Timing
- Reset (rst low, asynchronous): count=0, head pointer=0, all slot fields 0. Consequently out_valid=0, out_wen=0, out_waddr=0, out_wdata=0, lkp_hit=0, lkp_data=0, in_ready=1.
- An asynchronous reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N appears on out_* in the cycle after edge N, if the buffer was empty.
- Throughput: one entry per cycle while out_ready=1.
- When out_ready drops, the stage absorbs one more entry and then deasserts in_ready. Once count is 2, in_ready is 0 from the next cycle on.
- Head contents are stable while out_valid=1 and out_ready=0.
- A flush at edge N makes out_valid=0 and in_ready=1 in the cycle after edge N.

## Configuration
- WB_SKID_STAGE_X0_FILTER_EN defined: at push, channel 0's wen is forced to 0 when in_waddr[0 +: AW]==0 (writes to x0 are suppressed). The entry is still stored, and lookup for address 0 on channel 0 never hits.
- WB_SKID_STAGE_X0_FILTER_EN undefined: wen is stored unmodified.

## Structure
- Shared package wb_stage_pkg:
  - defaults WB_NCH=2, WB_DW=64, WB_AW=12
  - channel index constants CH_GPR=0, CH_CSR=1
  - packed struct type wb_entry_t (valid, wen, waddr, wdata) for the default sizing
- One sub-module, wb_skid_slot: a single storage slot with async active-low clear, synchronous write-enable and synchronous clear (used for pop and flush). It is instantiated twice.
- Top level holds the count/pointer control, output muxing and the per-channel lookup comparators.

## Test plan
- Reset then single push with wen=2'b11, addr {0x300, 0x05}, data {0xAA, 0x11}, out_ready=1 → out_valid=1 next cycle with the same fields; out_valid=0 the following cycle.
- Stall: out_ready=0, push E1 then E2 → in_ready=0 after E2. Raise out_ready → E1 then E2 drain in order, and in_ready returns to 1.
- Push and pop at count 1 for 8 back-to-back cycles → count stays 1 and the output shows each entry exactly one cycle after its push.
- Lookup with two slots both writing GPR 0x05 (data 0x11 older, 0x22 newer), lkp_addr[0]=0x05 → lkp_hit[0]=1, lkp_data[0]=0x22. lkp_addr[1] with no CSR match → hit 0, data 0.
- Flush with count=2 and a simultaneous push → next cycle out_valid=0, in_ready=1, no lookup hits.
- With WB_SKID_STAGE_X0_FILTER_EN, push wen[0]=1, addr 0, data 0x55 → out_wen[0]=0 and lkp_hit[0]=0 for address 0. Without the macro → out_wen[0]=1. Also: assert rst mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the MEM->WB skid stage: default sizing, channel
// indices and a packed entry type matching the default configuration.
package wb_stage_pkg;

  localparam int WB_NCH = 2;
  localparam int WB_DW  = 64;
  localparam int WB_AW  = 12;

  localparam int CH_GPR = 0;
  localparam int CH_CSR = 1;

  typedef struct packed {
    logic                    valid;
    logic [WB_NCH-1:0]       wen;
    logic [WB_NCH*WB_AW-1:0] waddr;
    logic [WB_NCH*WB_DW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_slot.sv
// One storage slot of the write-back skid buffer. A write loads all fields
// and sets valid; a clear drops only the valid bit so the raw contents stay
// visible on the head outputs. Write wins over clear, although the control
// never asks for both on the same slot.
module wb_skid_slot
  import wb_stage_pkg::*;
#(
  parameter int NCH = WB_NCH,
  parameter int DW  = WB_DW,
  parameter int AW  = WB_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               clr,
  input  logic [NCH-1:0]     wen_d,
  input  logic [NCH*AW-1:0]  waddr_d,
  input  logic [NCH*DW-1:0]  wdata_d,
  output logic               valid,
  output logic [NCH-1:0]     wen,
  output logic [NCH*AW-1:0]  waddr,
  output logic [NCH*DW-1:0]  wdata
);

  // Slot register: async clear on reset, sync load or sync invalidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      wen   <= '0;
      waddr <= '0;
      wdata <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      wen   <= wen_d;
      waddr <= waddr_d;
      wdata <= wdata_d;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_skid_stage.sv
// MEM->WB pipeline stage: NCH write-back channels through a 2-entry skid
// buffer with valid/ready handshake, plus a combinational lookup port so
// hazard logic can forward data still held here.
// Optional build macro WB_SKID_STAGE_X0_FILTER_EN: suppress channel-0 writes
// to address 0 at push time (the entry is still stored).
module wb_skid_stage
  import wb_stage_pkg::*;
#(
  parameter int NCH = WB_NCH,
  parameter int DW  = WB_DW,
  parameter int AW  = WB_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH-1:0]     in_wen,
  input  logic [NCH*AW-1:0]  in_waddr,
  input  logic [NCH*DW-1:0]  in_wdata,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH-1:0]     out_wen,
  output logic [NCH*AW-1:0]  out_waddr,
  output logic [NCH*DW-1:0]  out_wdata,
  input  logic [NCH*AW-1:0]  lkp_addr,
  output logic [NCH-1:0]     lkp_hit,
  output logic [NCH*DW-1:0]  lkp_data
);

  logic [1:0]     count;
  logic           head_ptr;
  logic           tail_ptr;
  logic           push;
  logic           pop;
  logic [NCH-1:0] wen_store;

  logic              s_valid [2];
  logic [NCH-1:0]    s_wen   [2];
  logic [NCH*AW-1:0] s_waddr [2];
  logic [NCH*DW-1:0] s_wdata [2];

  // Handshake is purely a function of registered occupancy, so in_ready
  // never combinationally depends on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);

  // Flush overrides both handshakes; the incoming entry is dropped.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Tail is the slot after the head when one entry is held, else the head.
  assign tail_ptr = head_ptr ^ count[0];

  // Write enables as stored; x0 writes on channel 0 optionally suppressed.
  always_comb begin
    wen_store = in_wen;
`ifdef WB_SKID_STAGE_X0_FILTER_EN
    if (in_waddr[0 +: AW] == '0) begin
      wen_store[0] = 1'b0;
    end
`endif
  end

  // Occupancy count and head pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= 2'd0;
      head_ptr <= 1'b0;
    end else if (flush) begin
      count    <= 2'd0;
      head_ptr <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    localparam logic IDX = 1'(i);
    logic slot_wr;
    logic slot_clr;

    assign slot_wr  = push & (tail_ptr == IDX);
    assign slot_clr = flush | (pop & (head_ptr == IDX));

    wb_skid_slot #(
      .NCH (NCH),
      .DW  (DW),
      .AW  (AW)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr      (slot_wr),
      .clr     (slot_clr),
      .wen_d   (wen_store),
      .waddr_d (in_waddr),
      .wdata_d (in_wdata),
      .valid   (s_valid[i]),
      .wen     (s_wen[i]),
      .waddr   (s_waddr[i]),
      .wdata   (s_wdata[i])
    );
  end

  // Head outputs: raw slot contents, write enables qualified by out_valid.
  assign out_wen   = s_wen[head_ptr] & {NCH{out_valid}};
  assign out_waddr = s_waddr[head_ptr];
  assign out_wdata = s_wdata[head_ptr];

  for (genvar c = 0; c < NCH; c++) begin : g_lkp
    logic          hit_c;
    logic [DW-1:0] data_c;
    logic          older;
    logic          newer;

    // The slot opposite the head is only valid when it is the newer entry.
    assign older = head_ptr;
    assign newer = ~head_ptr;

    // Per-channel lookup: the newer matching slot overrides the older one.
    always_comb begin
      hit_c  = 1'b0;
      data_c = '0;
      if (s_valid[older] && s_wen[older][c] &&
          (s_waddr[older][c*AW +: AW] == lkp_addr[c*AW +: AW])) begin
        hit_c  = 1'b1;
        data_c = s_wdata[older][c*DW +: DW];
      end
      if (s_valid[newer] && s_wen[newer][c] &&
          (s_waddr[newer][c*AW +: AW] == lkp_addr[c*AW +: AW])) begin
        hit_c  = 1'b1;
        data_c = s_wdata[newer][c*DW +: DW];
      end
    end

    assign lkp_hit[c]            = hit_c;
    assign lkp_data[c*DW +: DW]  = data_c;
  end

endmodule

// File: tb/tb_wb_skid_stage.sv
// Scoreboard bench for wb_skid_stage: accepted entries are queued as the
// expected write-back sequence; a negedge monitor compares handshake, head
// contents and lookup results against that queue.
module tb_wb_skid_stage;
  import wb_stage_pkg::*;

  localparam int NCH = WB_NCH;
  localparam int DW  = WB_DW;
  localparam int AW  = WB_AW;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NCH-1:0]    in_wen;
  logic [NCH*AW-1:0] in_waddr;
  logic [NCH*DW-1:0] in_wdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [NCH-1:0]    out_wen;
  logic [NCH*AW-1:0] out_waddr;
  logic [NCH*DW-1:0] out_wdata;
  logic [NCH*AW-1:0] lkp_addr;
  logic [NCH-1:0]    lkp_hit;
  logic [NCH*DW-1:0] lkp_data;

  wb_skid_stage #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wen    (in_wen),
    .in_waddr  (in_waddr),
    .in_wdata  (in_wdata),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wen   (out_wen),
    .out_waddr (out_waddr),
    .out_wdata (out_wdata),
    .lkp_addr  (lkp_addr),
    .lkp_hit   (lkp_hit),
    .lkp_data  (lkp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  wb_entry_t exp_q[$];
  wb_entry_t pend;
  bit        pend_v = 1'b0;
  bit        mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic wb_entry_t mk(input logic [NCH-1:0] w, input logic [NCH*AW-1:0] a,
                                   input logic [NCH*DW-1:0] d);
    wb_entry_t e;
    e.valid = 1'b1;
    e.wen   = w;
    e.waddr = a;
    e.wdata = d;
`ifdef WB_SKID_STAGE_X0_FILTER_EN
    if (a[AW-1:0] == '0) e.wen[0] = 1'b0;
`endif
    return e;
  endfunction

  // One cycle of stimulus: commit last cycle's accepted entry at the edge,
  // then drive new inputs and decide acceptance from the model occupancy.
  task automatic step(input logic iv, input logic [NCH-1:0] w, input logic [NCH*AW-1:0] a,
                      input logic [NCH*DW-1:0] d, input logic ordy, input logic fl,
                      input logic [NCH*AW-1:0] la);
    @(posedge clk);
    if (pend_v) exp_q.push_back(pend);
    pend_v = 1'b0;
    #1;
    in_valid  = iv;
    in_wen    = w;
    in_waddr  = a;
    in_wdata  = d;
    out_ready = ordy;
    flush     = fl;
    lkp_addr  = la;
    if (iv && !fl && exp_q.size() < 2) begin
      pend   = mk(w, a, d);
      pend_v = 1'b1;
    end
  endtask

  task automatic monitor_cycle();
    int n;
    logic [NCH-1:0]    e_hit;
    logic [NCH*DW-1:0] e_data;
    n = exp_q.size();
    e_hit  = '0;
    e_data = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < n; i++) begin
        if (exp_q[i].wen[c] && exp_q[i].waddr[c*AW +: AW] == lkp_addr[c*AW +: AW]) begin
          e_hit[c]            = 1'b1;
          e_data[c*DW +: DW]  = exp_q[i].wdata[c*DW +: DW];
        end
      end
    end
    chk("out_valid", 128'(out_valid), 128'(n != 0));
    chk("in_ready", 128'(in_ready), 128'(n != 2));
    if (n > 0) begin
      chk("out_wen", 128'(out_wen), 128'(exp_q[0].wen));
      chk("out_waddr", 128'(out_waddr), 128'(exp_q[0].waddr));
      chk("out_wdata", out_wdata, exp_q[0].wdata);
    end else begin
      chk("out_wen_idle", 128'(out_wen), 128'(0));
    end
    chk("lkp_hit", 128'(lkp_hit), 128'(e_hit));
    chk("lkp_data", lkp_data, e_data);
    if (flush) exp_q.delete();
    else if (out_ready && n > 0) void'(exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_en) monitor_cycle();
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_wen"}, 128'(out_wen), 128'(0));
    chk({tag, "_out_waddr"}, 128'(out_waddr), 128'(0));
    chk({tag, "_out_wdata"}, out_wdata, 128'(0));
    chk({tag, "_lkp_hit"}, 128'(lkp_hit), 128'(0));
    chk({tag, "_lkp_data"}, lkp_data, 128'(0));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  localparam logic [23:0] A_E = {12'h300, 12'h005};
  localparam logic [23:0] A_5 = {12'h000, 12'h005};

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NCH*AW-1:0] ra;
    logic [NCH*AW-1:0] rl;
    rst = 1'b0;
    in_valid = 1'b0; in_wen = '0; in_waddr = '0; in_wdata = '0;
    flush = 1'b0; out_ready = 1'b0; lkp_addr = '0;
    #2;
    chk_zero_outputs("reset");
    #20;
    rst = 1'b1;
    mon_en = 1'b1;

    // single push with immediate drain
    step(1, 2'b11, A_E, {64'hAA, 64'h11}, 1, 0, A_E);
    step(0, 0, 0, 0, 1, 0, A_E);
    step(0, 0, 0, 0, 1, 0, A_E);

    // stall, fill, rejected third push, then drain in order
    step(1, 2'b01, 24'h001_001, {64'h0, 64'hE1}, 0, 0, 24'h001_001);
    step(1, 2'b11, 24'h002_002, {64'hC2, 64'hE2}, 0, 0, 24'h001_001);
    step(1, 2'b11, 24'h003_003, {64'hC3, 64'hE3}, 0, 0, 24'h002_002);
    step(0, 0, 0, 0, 0, 0, 24'h002_002);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);

    // push and pop every cycle at count 1
    step(1, 2'b01, 24'h000_010, {64'h0, 64'h100}, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      step(1, 2'b11, 24'(i), {64'(i + 64'h200), 64'(i + 64'h300)}, 1, 0, 24'(i));
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // newest-match lookup on GPR 5, no CSR match
    step(1, 2'b01, A_5, {64'h0, 64'h11}, 0, 0, 0);
    step(1, 2'b01, A_5, {64'h0, 64'h22}, 0, 0, A_5);
    step(0, 0, 0, 0, 0, 0, {12'h123, 12'h005});

    // flush while full with a simultaneous push
    step(1, 2'b11, A_5, {64'h33, 64'h33}, 1, 1, A_5);
    step(0, 0, 0, 0, 0, 0, A_5);

    // channel-0 write to address 0
    step(1, 2'b01, 24'h000_000, {64'h0, 64'h55}, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ra = {12'($urandom_range(0, 3)), 12'($urandom_range(0, 3))};
      rl = {12'($urandom_range(0, 3)), 12'($urandom_range(0, 3))};
      step(($urandom_range(0, 3) != 0), 2'($urandom), ra,
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 4) < 3), ($urandom_range(0, 31) == 0), rl);
    end

    // asynchronous reset in the middle of a drain
    step(0, 0, 0, 0, 1, 1, 0);
    step(1, 2'b11, 24'h00A_00A, {64'hAB, 64'hCD}, 0, 0, 0);
    step(1, 2'b11, 24'h00B_00B, {64'hEF, 64'h12}, 0, 0, 24'h00A_00A);
    step(0, 0, 0, 0, 1, 0, 24'h00A_00A);
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    exp_q.delete();
    pend_v = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    mon_en = 1'b1;
    step(1, 2'b10, 24'h7FF_000, {64'h99, 64'h0}, 1, 0, 24'h7FF_000);
    step(0, 0, 0, 0, 1, 0, 24'h7FF_000);
    step(0, 0, 0, 0, 1, 0, 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
